// File: rtl/stack_sequencer.sv
// Stack transfer sequencer: walks push then pop masks one word per bus slot,
// producing SS-relative word offsets and register-file read/write strobes.
module stack_sequencer #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       push_mask,
    input  logic [15:0]       pop_mask,
    input  logic [ADDR_W-1:0] sp_in,
    input  logic [15:0]       operand_in,
    output logic [3:0]        reg_rd_sel,
    input  logic [15:0]       reg_rd_data,
    output logic              reg_wr_en,
    output logic [3:0]        reg_wr_sel,
    output logic [15:0]       reg_wr_data,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic [ADDR_W-1:0] sp_out,
    output logic              sp_we,
    output logic              busy,
    output logic              done
);
    localparam logic [3:0]  STACK_SP         = 4'd4;
    localparam logic [3:0]  STACK_SP_DISCARD = 4'd5;
    localparam logic [3:0]  STACK_OPERAND    = 4'd15;
    localparam logic [15:0] DISCARD_MASK     = 16'h0020;

    typedef enum logic [1:0] {S_IDLE, S_PUSH, S_POP, S_FINISH} state_t;

    state_t            r_state;
    logic [15:0]       r_push;
    logic [15:0]       r_pop;
    logic [ADDR_W-1:0] r_sp_cur;
    logic [ADDR_W-1:0] r_sp_orig;

    logic [3:0]        w_push_bit;
    logic [3:0]        w_pop_bit;
    logic [15:0]       w_push_rem;
    logic [15:0]       w_pop_rem;
    logic [15:0]       w_start_push;
    logic              w_pop_is_sp;

    function automatic logic [3:0] f_lowest(input logic [15:0] m);
        f_lowest = 4'd0;
        for (int i = 15; i >= 0; i--)
            if (m[i]) f_lowest = 4'(i);
    endfunction

    function automatic logic [3:0] f_highest(input logic [15:0] m);
        f_highest = 4'd0;
        for (int i = 0; i < 16; i++)
            if (m[i]) f_highest = 4'(i);
    endfunction

    assign w_push_bit   = f_lowest(r_push);
    assign w_pop_bit    = f_highest(r_pop);
    assign w_push_rem   = r_push & ~(16'd1 << w_push_bit);
    assign w_pop_rem    = r_pop & ~(16'd1 << w_pop_bit);
    // The discard bit never occupies a push slot, so drop it at latch time.
    assign w_start_push = push_mask & ~DISCARD_MASK;
    assign w_pop_is_sp  = (w_pop_bit == STACK_SP) || (w_pop_bit == STACK_SP_DISCARD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_push    <= '0;
            r_pop     <= '0;
            r_sp_cur  <= '0;
            r_sp_orig <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_push    <= w_start_push;
                    r_pop     <= pop_mask;
                    r_sp_cur  <= sp_in;
                    r_sp_orig <= sp_in;
                    if (w_start_push != '0)  r_state <= S_PUSH;
                    else if (pop_mask != '0) r_state <= S_POP;
                    else                     r_state <= S_FINISH;
                end
                S_PUSH: if (mem_ack) begin
                    r_push   <= w_push_rem;
                    r_sp_cur <= r_sp_cur - ADDR_W'(2);
                    if (w_push_rem == '0)
                        r_state <= (r_pop != '0) ? S_POP : S_FINISH;
                end
                S_POP: if (mem_ack) begin
                    r_pop    <= w_pop_rem;
                    r_sp_cur <= r_sp_cur + ADDR_W'(2);
                    if (w_pop_rem == '0) r_state <= S_FINISH;
                end
                S_FINISH: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // All outputs are decoded from registered state so they hold steady
    // for the whole time mem_req waits on mem_ack.
    always_comb begin
        busy        = (r_state != S_IDLE);
        mem_req     = (r_state == S_PUSH) || (r_state == S_POP);
        mem_wr      = (r_state == S_PUSH);
        mem_addr    = '0;
        mem_wdata   = '0;
        reg_rd_sel  = '0;
        reg_wr_en   = 1'b0;
        reg_wr_sel  = '0;
        reg_wr_data = '0;
        done        = (r_state == S_FINISH);
        sp_we       = (r_state == S_FINISH);
        sp_out      = (r_state == S_FINISH) ? r_sp_cur : '0;
        if (r_state == S_PUSH) begin
            mem_addr   = r_sp_cur - ADDR_W'(2);
            reg_rd_sel = w_push_bit;
            if (w_push_bit == STACK_SP)           mem_wdata = 16'(r_sp_orig);
            else if (w_push_bit == STACK_OPERAND) mem_wdata = operand_in;
            else                                  mem_wdata = reg_rd_data;
        end else if (r_state == S_POP) begin
            mem_addr = r_sp_cur;
            if (mem_ack && !w_pop_is_sp) begin
                reg_wr_en   = 1'b1;
                reg_wr_sel  = w_pop_bit;
                reg_wr_data = mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_stack_sequencer.sv
// Randomized bench for stack_sequencer against a transaction-list reference model.
module tb_stack_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] push_mask = '0, pop_mask = '0, sp_in = '0, operand_in = '0;
    logic [3:0]  reg_rd_sel;
    logic [15:0] reg_rd_data;
    logic        reg_wr_en;
    logic [3:0]  reg_wr_sel;
    logic [15:0] reg_wr_data;
    logic        mem_req, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata;
    logic [15:0] sp_out;
    logic        sp_we, busy, done;

    logic [15:0] tbmem [0:65535];
    logic [15:0] regfile [0:15];

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
        bit          rw;
        logic [3:0]  sel;
    } exp_t;
    exp_t        exp_q[$];
    logic [15:0] exp_sp;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    assign reg_rd_data = regfile[reg_rd_sel];
    assign mem_rdata   = tbmem[mem_addr];

    stack_sequencer #(.ADDR_W(16)) dut (
        .clk(clk), .reset(reset), .start(start),
        .push_mask(push_mask), .pop_mask(pop_mask), .sp_in(sp_in), .operand_in(operand_in),
        .reg_rd_sel(reg_rd_sel), .reg_rd_data(reg_rd_data),
        .reg_wr_en(reg_wr_en), .reg_wr_sel(reg_wr_sel), .reg_wr_data(reg_wr_data),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .sp_out(sp_out), .sp_we(sp_we), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Stack semantics: pushes go ascending with pre-decrement, pops descending
    // reading whatever memory holds, including words pushed earlier in the run.
    task automatic model(input logic [15:0] pm, input logic [15:0] qm,
                         input logic [15:0] sp, input logic [15:0] opnd);
        logic [15:0] shadow [logic [15:0]];
        logic [15:0] s;
        exp_t e;
        s = sp;
        exp_q.delete();
        for (int b = 0; b < 16; b++) begin
            if (pm[b] && b != 5) begin
                s = s - 16'd2;
                e.wr = 1; e.addr = s; e.rw = 0; e.sel = 4'(b);
                e.data = (b == 4) ? sp : (b == 15) ? opnd : regfile[b];
                shadow[s] = e.data;
                exp_q.push_back(e);
            end
        end
        for (int b = 15; b >= 0; b--) begin
            if (qm[b]) begin
                e.wr = 0; e.addr = s; e.sel = 4'(b);
                e.rw = (b != 4 && b != 5);
                e.data = shadow.exists(s) ? shadow[s] : tbmem[s];
                exp_q.push_back(e);
                s = s + 16'd2;
            end
        end
        exp_sp = s;
    endtask

    task automatic check_quiet(input string tag);
        check(tag, {28'd0, mem_req, busy, done, sp_we}, 32'd0);
    endtask

    // dly >= 0: fixed ack delay per slot, < 0: random 0..3.
    // abort_at >= 0: assert reset while waiting in that slot index.
    task automatic run_seq(input logic [15:0] pm, input logic [15:0] qm,
                           input logic [15:0] sp, input logic [15:0] opnd,
                           input int dly, input int abort_at, input bit poke,
                           output logic [15:0] sp_obs);
        int slots, waited, tgt, waits, eslots;
        bit fin;
        logic [15:0] pa, pd;
        logic pw;
        exp_t e;
        for (int i = 0; i < 16; i++) regfile[i] = 16'($urandom);
        model(pm, qm, sp, opnd);
        eslots = exp_q.size();
        slots = 0; waited = 0; tgt = 0; waits = 0; fin = 0; sp_obs = '0;
        pa = '0; pd = '0; pw = 0;
        @(negedge clk);
        start = 1; push_mask = pm; pop_mask = qm; sp_in = sp; operand_in = opnd;
        for (int k = 1; k <= 400 && !fin; k++) begin
            @(negedge clk);
            start = 0;
            if (k == 1 && poke) begin
                start = 1; push_mask = 16'($urandom); pop_mask = 16'($urandom); sp_in = 16'($urandom);
            end
            if (k == 1) check("first_req", {31'd0, mem_req}, {31'd0, eslots > 0});
            if (abort_at >= 0 && slots == abort_at && mem_req) begin
                mem_ack = 0;
                #2 reset = 1;
                #1 check("rst_outs", {mem_req, busy, done, sp_we, reg_wr_en, mem_wr, reg_wr_sel, reg_rd_sel},
                         32'd0);
                check("rst_addr", {mem_addr, sp_out}, 32'd0);
                exp_q.delete();
                return;
            end
            if (done) begin
                check("done_cyc", k, eslots + waits + 1);
                check("sp_out", sp_out, exp_sp);
                check("sp_we_busy", {30'd0, sp_we, busy}, 32'd3);
                check("slots_left", exp_q.size(), 0);
                sp_obs = sp_out;
                fin = 1;
            end else if (mem_req) begin
                if (waited == 0) begin
                    tgt = (dly >= 0) ? dly : int'($urandom_range(0, 3));
                    waits += tgt;
                end else begin
                    check("stable", {15'd0, mem_wr, mem_addr ^ mem_wdata}, {15'd0, pw, pa ^ pd});
                    check("stable_a", mem_addr, pa);
                end
                pa = mem_addr; pd = mem_wdata; pw = mem_wr;
                if (waited == tgt) begin
                    mem_ack = 1;
                    #1;
                    if (exp_q.size() == 0) check("extra_slot", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("wr", {31'd0, mem_wr}, {31'd0, e.wr});
                        check("addr", mem_addr, e.addr);
                        check("rwen", {31'd0, reg_wr_en}, {31'd0, e.rw});
                        if (e.wr) check("wdata", mem_wdata, e.data);
                        if (e.rw) check("rwdata", {reg_wr_sel, reg_wr_data}, {e.sel, e.data});
                    end
                    if (mem_wr) tbmem[mem_addr] = mem_wdata;
                    waited = 0; slots++;
                end else begin
                    mem_ack = 0;
                    waited++;
                end
            end else mem_ack = 0;
        end
        mem_ack = 0; start = 0;
        if (!fin) check("timeout", 0, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_quiet("idle_after");
        end
    endtask

    initial begin
        logic [15:0] spo;
        for (int i = 0; i < 65536; i++) tbmem[i] = 16'($urandom);
        repeat (2) @(negedge clk);
        check_quiet("reset_state");
        check("reset_sp", sp_out, 16'h0000);
        reset = 0;
        @(negedge clk);
        check_quiet("idle");

        run_seq(16'h01DF, 16'h0000, 16'h1000, 16'h0000, 0, -1, 0, spo);
        check("pushr_sp", spo, 16'h0FF0);
        check("pushr_sp_word", tbmem[16'h0FF6], 16'h1000);
        run_seq(16'h0000, 16'h01EF, 16'h0FF0, 16'h0000, 0, -1, 0, spo);
        check("popr_sp", spo, 16'h1000);
        run_seq(16'h4C00, 16'h0000, 16'h0002, 16'h0000, 3, -1, 0, spo);
        check("int_sp", spo, 16'hFFFC);
        run_seq(16'h8000, 16'h0001, 16'h0100, 16'hBEEF, 0, -1, 0, spo);
        check("comb_sp", spo, 16'h0100);
        check("comb_mem", tbmem[16'h00FE], 16'hBEEF);
        run_seq(16'h0000, 16'h0000, 16'h1234, 16'h0000, 0, -1, 1, spo);
        check("empty_sp", spo, 16'h1234);
        run_seq(16'h0020, 16'h0000, 16'h0040, 16'h0000, 0, -1, 0, spo);
        check("discard_only_sp", spo, 16'h0040);

        run_seq(16'h01DF, 16'h0000, 16'h2000, 16'h0000, 0, 2, 0, spo);
        @(negedge clk);
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_quiet("post_abort");
        end
        run_seq(16'h0003, 16'h0000, 16'h3000, 16'h0000, 0, -1, 0, spo);
        check("rerun_sp", spo, 16'h2FFC);

        for (int t = 0; t < 25; t++) begin
            logic [15:0] pm, qm;
            pm = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
            qm = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
            run_seq(pm, qm, 16'($urandom), 16'($urandom), -1, -1, 1'($urandom), spo);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
- Sequences multi-register stack transfers for the V30 core: PUSH R/POP R, interrupt entry (PSW, PS, PC), RETI/RET and single-operand push/pop.
- Consumes the 16-bit push/pop masks produced by pre-decode (STACK_* bit assignments) and walks them one word per bus transaction.
- Sits between the execute unit, the register file and the bus interface unit.
- Computes SS-relative offsets only; segment relocation is done downstream.

Parameters:
- ADDR_W, 16, width of SP and stack offset.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; masks and SP sampled this cycle
- push_mask  in  16  STACK_* bits to push
- pop_mask  in  16  STACK_* bits to pop
- sp_in  in  16  current SP value
- operand_in  in  16  value pushed for STACK_OPERAND
- reg_rd_sel  out  4  bit index of register being pushed (combinational read)
- reg_rd_data  in  16  register file read data for reg_rd_sel, same cycle
- reg_wr_en  out  1  popped-register write strobe
- reg_wr_sel  out  4  bit index being written
- reg_wr_data  out  16  popped value
- mem_req  out  1  bus request, held until mem_ack
- mem_wr  out  1  1 = write (push), 0 = read (pop)
- mem_addr  out  16  SS-relative word offset
- mem_wdata  out  16  push data
- mem_ack  in  1  transaction complete; mem_rdata valid this cycle
- mem_rdata  in  16  read data
- sp_out  out  16  final SP
- sp_we  out  1  one-cycle SP write strobe
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: state IDLE; all outputs 0; internal masks and SP cleared. Reset mid-sequence abandons it; no done or sp_we is issued.
- IDLE: on start, latch push_mask, pop_mask and sp_in into sp_cur and sp_orig, then go to PUSH. start while busy is ignored.
- Push order is ascending bit index (AW first, PC/OPERAND last).
- Pop order is descending bit index (OPERAND/PC first, AW last).
- When both masks are non-zero, all pushes complete before any pop.
- PUSH: select the lowest set bit b; mem_addr = sp_cur - 2; mem_wr = 1; mem_req = 1.
- Push data source: STACK_SP pushes sp_orig; STACK_OPERAND pushes operand_in; all other bits push reg_rd_data with reg_rd_sel = b.
- On mem_ack in PUSH: sp_cur -= 2 (mod 2^16) and clear bit b.
- STACK_SP_DISCARD in push_mask is ignored and consumes no slot.
- When push_mask is empty, go to POP.
- POP: select the highest set bit b; mem_addr = sp_cur; mem_wr = 0; mem_req = 1.
- On mem_ack in POP: sp_cur += 2 and clear bit b. In the same cycle, reg_wr_en = 1 with reg_wr_sel = b and reg_wr_data = mem_rdata.
- Exception in POP: STACK_SP and STACK_SP_DISCARD bits produce no register write; SP is only adjusted.
- When pop_mask is empty, go to FINISH.
- FINISH, one cycle: sp_we = 1, sp_out = sp_cur, done = 1; then IDLE.
- busy = 1 in every state except IDLE.
- Bus handshake: mem_addr, mem_wr and mem_wdata stay stable while mem_req is high. mem_req may drop for zero cycles between back-to-back slots.
- Latency: start at cycle N gives the first mem_req at N+1. With mem_ack held high, each slot takes 1 cycle.
- An empty sequence (both masks 0) gives done and sp_we at N+1 with sp_out = sp_in.
- SP wrap-around is modulo 2^16 with no fault: 0x0000 - 2 = 0xFFFE.

Test Plan:
- PUSH R: push_mask=0x01DF, sp_in=0x1000, mem_ack tied 1 -> 8 writes at 0x0FFE down to 0x0FF0 in order AW,CW,DW,BW,SP(=0x1000),BP,IX,IY; sp_out=0x0FF0; done at cycle N+9.
- POP R: pop_mask=0x01EF, sp_in=0x0FF0 -> reads at 0x0FF0..0x0FFE. Order IY,IX,BP,discard,BW,DW,CW,AW; no reg_wr_en on the discard slot; sp_out=0x1000.
- Interrupt entry: push_mask=0x4C00, sp_in=0x0002 with 3-cycle ack delay -> writes PSW@0x0000, PS@0xFFFE, PC@0xFFFC; mem_addr stable while waiting; sp_out=0xFFFC.
- Combined push and pop: push_mask=0x8000, pop_mask=0x0001, operand_in=0xBEEF, sp_in=0x0100 -> write 0xBEEF @0x00FE, then read @0x00FE into AW; sp_out=0x0100.
- Empty masks with sp_in=0x1234, plus start asserted again while busy -> done/sp_we at N+1 with sp_out=0x1234; the second start produces no extra transaction.
- Reset asserted during the 3rd PUSH slot -> outputs 0 immediately; no done or sp_we; next start runs normally.
